// File: rtl/fwd_ctrl_unit.sv
// EX-stage operand forwarding control.
// Compares the ID/EX source registers against the EX/MEM and MEM/WB destinations and
// selects the ALU operand-mux source for rs and rt. Also keeps saturating forwarding
// event counters for performance debug.
// Optional build macro: FWD_REG_OUT_EN registers the select outputs (latency 1).
module fwd_ctrl_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_xm,
  input  logic              reg_write_mw,
  input  logic [REG_AW-1:0] rd_register_xm,
  input  logic [REG_AW-1:0] rd_register_mw,
  input  logic [REG_AW-1:0] rs_register_dx,
  input  logic [REG_AW-1:0] rt_register_dx,
  output logic [1:0]        fwdctrl_rs,
  output logic [1:0]        fwdctrl_rt,
  output logic [CNT_W-1:0]  xm_fwd_count,
  output logic [CNT_W-1:0]  mw_fwd_count
);

  localparam logic [1:0]       SelRf  = 2'b00;
  localparam logic [1:0]       SelXm  = 2'b10;
  localparam logic [1:0]       SelMw  = 2'b01;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic       xm_valid, mw_valid;
  logic       hit_rs_xm, hit_rs_mw, hit_rt_xm, hit_rt_mw;
  logic [1:0] rs_sel, rt_sel;
  logic       xm_evt, mw_evt;

  logic [CNT_W-1:0] xm_cnt_q, xm_cnt_d;
  logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

  // Hit detection: a stage forwards only if it writes a register other than r0.
  always_comb begin
    xm_valid  = reg_write_xm && (rd_register_xm != '0);
    mw_valid  = reg_write_mw && (rd_register_mw != '0);
    hit_rs_xm = xm_valid && (rd_register_xm == rs_register_dx);
    hit_rs_mw = mw_valid && (rd_register_mw == rs_register_dx);
    hit_rt_xm = xm_valid && (rd_register_xm == rt_register_dx);
    hit_rt_mw = mw_valid && (rd_register_mw == rt_register_dx);
  end

  // Select decision per operand; XM (youngest result) wins over MW.
  always_comb begin
    rs_sel = SelRf;
    rt_sel = SelRf;
    if (hit_rs_xm) begin
      rs_sel = SelXm;
    end else if (hit_rs_mw) begin
      rs_sel = SelMw;
    end
    if (hit_rt_xm) begin
      rt_sel = SelXm;
    end else if (hit_rt_mw) begin
      rt_sel = SelMw;
    end
  end

  // Counter next-state: at most one increment per cycle, saturating at all-ones.
  always_comb begin
    xm_evt   = (rs_sel == SelXm) || (rt_sel == SelXm);
    mw_evt   = (rs_sel == SelMw) || (rt_sel == SelMw);
    xm_cnt_d = xm_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if (xm_evt && (xm_cnt_q != CntMax)) begin
      xm_cnt_d = xm_cnt_q + 1'b1;
    end
    if (mw_evt && (mw_cnt_q != CntMax)) begin
      mw_cnt_d = mw_cnt_q + 1'b1;
    end
  end

  // Counter registers; reset overrides any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      xm_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      xm_cnt_q <= xm_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign xm_fwd_count = xm_cnt_q;
  assign mw_fwd_count = mw_cnt_q;

`ifdef FWD_REG_OUT_EN
  logic [1:0] rs_sel_q, rt_sel_q;

  // Registered selects; counters above still use the current-cycle decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_sel_q <= SelRf;
      rt_sel_q <= SelRf;
    end else begin
      rs_sel_q <= rs_sel;
      rt_sel_q <= rt_sel;
    end
  end

  assign fwdctrl_rs = rs_sel_q;
  assign fwdctrl_rt = rt_sel_q;
`else
  assign fwdctrl_rs = rs_sel;
  assign fwdctrl_rt = rt_sel;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Self-checking bench for fwd_ctrl_unit. Expected selects go through a queue so the same
// sequence covers both the combinational and the registered-select build.
module tb_fwd_ctrl_unit;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef FWD_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_write_xm, reg_write_mw;
  logic [REG_AW-1:0] rd_register_xm, rd_register_mw, rs_register_dx, rt_register_dx;
  logic [1:0]        fwdctrl_rs, fwdctrl_rt;
  logic [CNT_W-1:0]  xm_fwd_count, mw_fwd_count;

  int errors = 0;
  int checks = 0;
  int exp_xm = 0;
  int exp_mw = 0;
  logic [3:0] sel_q[$];

  fwd_ctrl_unit #(
    .REG_AW(REG_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write_xm  (reg_write_xm),
    .reg_write_mw  (reg_write_mw),
    .rd_register_xm(rd_register_xm),
    .rd_register_mw(rd_register_mw),
    .rs_register_dx(rs_register_dx),
    .rt_register_dx(rt_register_dx),
    .fwdctrl_rs    (fwdctrl_rs),
    .fwdctrl_rt    (fwdctrl_rt),
    .xm_fwd_count  (xm_fwd_count),
    .mw_fwd_count  (mw_fwd_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_sel(input logic rwx, input logic rwm,
                                           input logic [REG_AW-1:0] rdx,
                                           input logic [REG_AW-1:0] rdm,
                                           input logic [REG_AW-1:0] src);
    if (rwx && rdx != 0 && rdx == src) return 2'b10;
    if (rwm && rdm != 0 && rdm == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock of stimulus: drive at negedge, check selects, then counters after the edge.
  task automatic step(input string tag, input logic rst, input logic rwx, input logic rwm,
                      input logic [REG_AW-1:0] rdx, input logic [REG_AW-1:0] rdm,
                      input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt);
    logic [1:0] ers, ert;
    logic [3:0] popped;
    reset          = rst;
    reg_write_xm   = rwx;
    reg_write_mw   = rwm;
    rd_register_xm = rdx;
    rd_register_mw = rdm;
    rs_register_dx = rs;
    rt_register_dx = rt;
    ers = model_sel(rwx, rwm, rdx, rdm, rs);
    ert = model_sel(rwx, rwm, rdx, rdm, rt);
    if (rst && LAT != 0) sel_q.push_back(4'b0000);
    else                 sel_q.push_back({ers, ert});
    #1;
    if (sel_q.size() > LAT) begin
      popped = sel_q.pop_front();
      check({tag, "/rs"}, int'(fwdctrl_rs), int'(popped[3:2]));
      check({tag, "/rt"}, int'(fwdctrl_rt), int'(popped[1:0]));
    end
    @(posedge clk);
    if (rst) begin
      exp_xm = 0;
      exp_mw = 0;
    end else begin
      if ((ers == 2'b10 || ert == 2'b10) && exp_xm < CNT_MAX) exp_xm++;
      if ((ers == 2'b01 || ert == 2'b01) && exp_mw < CNT_MAX) exp_mw++;
    end
    #1;
    check({tag, "/xm_cnt"}, int'(xm_fwd_count), exp_xm);
    check({tag, "/mw_cnt"}, int'(mw_fwd_count), exp_mw);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    step("idle", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    step("no_wr", 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) step("xm_both", 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 5'd1);
    for (int i = 0; i < 3; i++) step("mw_both", 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd3, 5'd3);
    step("prio", 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 5'd5);
    step("r0", 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    step("split", 1'b0, 1'b1, 1'b1, 5'd6, 5'd7, 5'd7, 5'd6);
    step("mw_rt", 1'b0, 1'b1, 1'b1, 5'd9, 5'd8, 5'd2, 5'd8);
    step("max_reg", 1'b0, 1'b0, 1'b1, 5'd0, 5'd31, 5'd31, 5'd0);
    for (int i = 0; i < 20; i++) step("sat_xm", 1'b0, 1'b1, 1'b0, 5'd12, 5'd0, 5'd12, 5'd3);
    for (int i = 0; i < 20; i++) step("sat_mw", 1'b0, 1'b0, 1'b1, 5'd0, 5'd13, 5'd1, 5'd13);
    step("rst_hit", 1'b1, 1'b1, 1'b1, 5'd12, 5'd13, 5'd12, 5'd13);
    for (int i = 0; i < 6; i++) begin
      step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    step("drain", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
